// File: rtl/mem_stage_sized.sv
// MIPS memory stage: sized/extended loads, lane-masked stores, misalign detect, MEM/WB register.
// Latency 1 cycle (LAT=0) or LAT+1 for memory ops; busy holds upstream while an access waits.
module mem_stage_sized #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int REG_W  = 5,
  parameter int LAT    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              flush,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        MemSize,
  input  logic              MemSigned,
  input  logic [REG_W-1:0]  WriteReg,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] WriteData,
  output logic              busy,
  output logic              valid_out,
  output logic              RegWriteOut,
  output logic              MemtoRegOut,
  output logic [REG_W-1:0]  WriteRegOut,
  output logic [DATA_W-1:0] ALUResultOut,
  output logic [DATA_W-1:0] MemOut,
  output logic              misalign
);

  localparam int DEPTH    = 2 ** ADDR_W;
  localparam bit HAS_WAIT = (LAT > 0);

  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                rw_q, rw_d;
  logic                m2r_q, m2r_d;
  logic                mis_q, mis_d;
  logic [REG_W-1:0]    wreg_q, wreg_d;
  logic [DATA_W-1:0]   alu_q, alu_d;
  logic [DATA_W-1:0]   memout_q, memout_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W+1:0]   baddr;
  logic [ADDR_W-1:0]   widx;
  logic [1:0]          lane;
  logic                mem_op;
  logic                mis;
  logic                complete;
  logic                we;
  logic [3:0]          be;
  logic [DATA_W-1:0]   wdat;
  logic [DATA_W-1:0]   rd_word;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [DATA_W-1:0]   ld_ext;
  logic                unused_hi;

  // Address bits above the array are deliberately dropped so accesses wrap.
  assign baddr     = ALUResult[ADDR_W+1:0];
  assign widx      = baddr[ADDR_W+1:2];
  assign lane      = baddr[1:0];
  assign unused_hi = ^ALUResult[DATA_W-1:ADDR_W+2];

  assign mem_op = valid_in & (MemRead | MemWrite);
  assign mis    = (MemRead | MemWrite) &
                  (((MemSize == 2'b01) & lane[0]) | (MemSize[1] & (lane != 2'b00)));

  assign rd_word  = mem[widx];
  assign byte_sel = rd_word[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_ext = rd_word;
    be     = 4'hf;
    wdat   = WriteData;
    case (MemSize)
      2'b00: begin
        ld_ext = {{(DATA_W-8){MemSigned & byte_sel[7]}}, byte_sel};
        be     = 4'b0001 << lane;
        wdat   = {4{WriteData[7:0]}};
      end
      2'b01: begin
        ld_ext = {{(DATA_W-16){MemSigned & half_sel[15]}}, half_sel};
        be     = lane[1] ? 4'b1100 : 4'b0011;
        wdat   = {2{WriteData[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    rw_d     = rw_q;
    m2r_d    = m2r_q;
    mis_d    = mis_q;
    wreg_d   = wreg_q;
    alu_d    = alu_q;
    memout_d = memout_q;
    complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_op && HAS_WAIT && !flush) begin
          state_d = S_WAIT;
          cnt_d   = 3'(LAT - 1);
          valid_d = 1'b0;
          rw_d    = 1'b0;
        end else if (valid_in && !flush) begin
          complete = 1'b1;
        end else begin
          valid_d = 1'b0;
          rw_d    = 1'b0;
          if (flush) mis_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
          valid_d = 1'b0;
          rw_d    = 1'b0;
          mis_d   = 1'b0;
        end else if (cnt_q == 3'd0) begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d   = cnt_q - 3'd1;
          valid_d = 1'b0;
          rw_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (complete) begin
      valid_d  = 1'b1;
      rw_d     = RegWrite & ~(MemRead & mis);
      m2r_d    = MemtoReg;
      wreg_d   = WriteReg;
      alu_d    = ALUResult;
      memout_d = (MemRead && !mis) ? ld_ext : '0;
      mis_d    = mis;
    end
  end

  // Gating with rst keeps a held store from landing while reset is asserted.
  assign we   = complete & MemWrite & ~mis & ~rst;
  assign busy = ~rst & ((state_q == S_WAIT) | (mem_op & HAS_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      valid_q  <= 1'b0;
      rw_q     <= 1'b0;
      m2r_q    <= 1'b0;
      mis_q    <= 1'b0;
      wreg_q   <= '0;
      alu_q    <= '0;
      memout_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      rw_q     <= rw_d;
      m2r_q    <= m2r_d;
      mis_q    <= mis_d;
      wreg_q   <= wreg_d;
      alu_q    <= alu_d;
      memout_q <= memout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  assign valid_out    = valid_q;
  assign RegWriteOut  = rw_q;
  assign MemtoRegOut  = m2r_q;
  assign WriteRegOut  = wreg_q;
  assign ALUResultOut = alu_q;
  assign MemOut       = memout_q;
  assign misalign     = mis_q;

endmodule

// File: tb/tb_mem_stage_sized.sv
// Bench for mem_stage_sized: a LAT=0 and a LAT=3 instance, each with its own scoreboard queue and monitor.
module tb_mem_stage_sized;

  typedef struct packed {
    logic        valid;
    logic        flush;
    logic        rw;
    logic        m2r;
    logic        mr;
    logic        mw;
    logic [1:0]  sz;
    logic        sg;
    logic [4:0]  wreg;
    logic [31:0] alu;
    logic [31:0] wd;
  } in_t;

  typedef struct packed {
    logic [31:0] memout;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic        rw;
    logic        m2r;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  in_t  in0 = '0;
  in_t  in3 = '0;

  logic        busy0, vo0, rwo0, m2ro0, mis0;
  logic [4:0]  wro0;
  logic [31:0] alu0, mo0;
  logic        busy3, vo3, rwo3, m2ro3, mis3;
  logic [4:0]  wro3;
  logic [31:0] alu3, mo3;

  exp_t q0[$];
  exp_t q3[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_stage_sized #(.DATA_W(32), .ADDR_W(10), .REG_W(5), .LAT(0)) u0 (
    .clk(clk), .rst(rst), .valid_in(in0.valid), .flush(in0.flush),
    .RegWrite(in0.rw), .MemtoReg(in0.m2r), .MemRead(in0.mr), .MemWrite(in0.mw),
    .MemSize(in0.sz), .MemSigned(in0.sg), .WriteReg(in0.wreg),
    .ALUResult(in0.alu), .WriteData(in0.wd),
    .busy(busy0), .valid_out(vo0), .RegWriteOut(rwo0), .MemtoRegOut(m2ro0),
    .WriteRegOut(wro0), .ALUResultOut(alu0), .MemOut(mo0), .misalign(mis0)
  );

  mem_stage_sized #(.DATA_W(32), .ADDR_W(10), .REG_W(5), .LAT(3)) u3 (
    .clk(clk), .rst(rst), .valid_in(in3.valid), .flush(in3.flush),
    .RegWrite(in3.rw), .MemtoReg(in3.m2r), .MemRead(in3.mr), .MemWrite(in3.mw),
    .MemSize(in3.sz), .MemSigned(in3.sg), .WriteReg(in3.wreg),
    .ALUResult(in3.alu), .WriteData(in3.wd),
    .busy(busy3), .valid_out(vo3), .RegWriteOut(rwo3), .MemtoRegOut(m2ro3),
    .WriteRegOut(wro3), .ALUResultOut(alu3), .MemOut(mo3), .misalign(mis3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input in_t s, input logic [31:0] em, input logic emis);
    exp_t e;
    e.memout = em;
    e.alu    = s.alu;
    e.wreg   = s.wreg;
    e.rw     = s.rw & ~(s.mr & emis);
    e.m2r    = s.m2r;
    e.mis    = emis;
    return e;
  endfunction

  function automatic in_t mk_in(input logic fl, rw, mr, mw, input logic [1:0] sz,
                                input logic sg, input logic [31:0] a, wd, input logic [4:0] wr);
    in_t s;
    s.valid = 1'b1; s.flush = fl; s.rw = rw; s.m2r = mr; s.mr = mr; s.mw = mw;
    s.sz = sz; s.sg = sg; s.wreg = wr; s.alu = a; s.wd = wd;
    return s;
  endfunction

  // LAT=0: drive for one cycle; the result is expected on the next edge.
  task automatic issue0(input logic fl, rw, mr, mw, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, wd, em, input logic emis);
    in0 = mk_in(fl, rw, mr, mw, sz, sg, a, wd, 5'd7);
    if (!fl) q0.push_back(mk_exp(in0, em, emis));
    #1 check("lat0_busy", {31'd0, busy0}, 32'd0);
    @(posedge clk); #1;
  endtask

  // LAT=3: hold for 4 cycles (IDLE + 3 WAIT); flush_at>=0 raises flush in that cycle and drops the op.
  task automatic issue3(input logic rw, mr, mw, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, wd, em, input logic emis, input int flush_at);
    in3 = mk_in(1'b0, rw, mr, mw, sz, sg, a, wd, 5'd9);
    if (flush_at < 0) q3.push_back(mk_exp(in3, em, emis));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("lat3_busy_c%0d", c), {31'd0, busy3}, 32'd1);
      if (c > 0) check($sformatf("lat3_wait_valid_c%0d", c), {31'd0, vo3}, 32'd0);
      if (c == flush_at) in3.flush = 1'b1;
      @(posedge clk); #1;
      if (c == flush_at) begin
        in3.valid = 1'b0;
        in3.flush = 1'b0;
        @(negedge clk);
        check("lat3_busy_after_flush", {31'd0, busy3}, 32'd0);
        @(posedge clk); #1;
        return;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && vo0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL lat0_unexpected_output: valid_out=1 with nothing expected, ALUResultOut=0x%08h", alu0);
      end else begin
        e = q0.pop_front();
        check("lat0_MemOut", mo0, e.memout);
        check("lat0_ALUResultOut", alu0, e.alu);
        check("lat0_WriteRegOut", {27'd0, wro0}, {27'd0, e.wreg});
        check("lat0_RegWriteOut", {31'd0, rwo0}, {31'd0, e.rw});
        check("lat0_MemtoRegOut", {31'd0, m2ro0}, {31'd0, e.m2r});
        check("lat0_misalign", {31'd0, mis0}, {31'd0, e.mis});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && vo3) begin
      if (q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL lat3_unexpected_output: valid_out=1 with nothing expected, ALUResultOut=0x%08h", alu3);
      end else begin
        e = q3.pop_front();
        check("lat3_MemOut", mo3, e.memout);
        check("lat3_ALUResultOut", alu3, e.alu);
        check("lat3_WriteRegOut", {27'd0, wro3}, {27'd0, e.wreg});
        check("lat3_RegWriteOut", {31'd0, rwo3}, {31'd0, e.rw});
        check("lat3_MemtoRegOut", {31'd0, m2ro3}, {31'd0, e.m2r});
        check("lat3_misalign", {31'd0, mis3}, {31'd0, e.mis});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_out0", {31'd0, vo0}, 32'd0);
    check("rst_outputs0", {rwo0, m2ro0, mis0, busy0, wro0} | alu0 | mo0, 32'd0);
    check("rst_valid_out3", {31'd0, vo3}, 32'd0);
    check("rst_outputs3", {rwo3, m2ro3, mis3, busy3, wro3} | alu3 | mo3, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // LAT=0 directed vectors: fl, rw, mr, mw, size, signed, addr, wdata, expected MemOut, misalign
    issue0(0, 0, 0, 1, 2'b10, 0, 32'h10,   32'hDEADBEEF, 32'h0,        0);
    issue0(0, 1, 1, 0, 2'b10, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0);
    issue0(0, 0, 0, 1, 2'b00, 0, 32'h13,   32'hAAAAAA80, 32'h0,        0);
    issue0(0, 1, 1, 0, 2'b00, 1, 32'h13,   32'h0,        32'hFFFFFF80, 0);
    issue0(0, 1, 1, 0, 2'b00, 0, 32'h13,   32'h0,        32'h00000080, 0);
    issue0(0, 1, 1, 0, 2'b10, 0, 32'h10,   32'h0,        32'h80ADBEEF, 0);
    issue0(0, 1, 1, 0, 2'b01, 1, 32'h10,   32'h0,        32'hFFFFBEEF, 0);
    issue0(0, 1, 1, 0, 2'b01, 1, 32'h12,   32'h0,        32'hFFFF80AD, 0);
    issue0(0, 1, 1, 0, 2'b01, 0, 32'h12,   32'h0,        32'h000080AD, 0);
    issue0(0, 1, 1, 0, 2'b00, 1, 32'h11,   32'h0,        32'hFFFFFFBE, 0);
    issue0(0, 0, 0, 1, 2'b10, 0, 32'h20,   32'h55667788, 32'h0,        0);
    issue0(0, 0, 0, 1, 2'b01, 0, 32'h22,   32'hFFFF1234, 32'h0,        0);
    issue0(0, 1, 1, 0, 2'b01, 1, 32'h22,   32'h0,        32'h00001234, 0);
    issue0(0, 1, 1, 0, 2'b10, 0, 32'h20,   32'h0,        32'h12347788, 0);
    issue0(0, 1, 1, 0, 2'b00, 1, 32'h20,   32'h0,        32'hFFFFFF88, 0);
    issue0(0, 1, 1, 0, 2'b00, 1, 32'h21,   32'h0,        32'h00000077, 0);
    issue0(0, 1, 1, 0, 2'b01, 0, 32'h20,   32'h0,        32'h00007788, 0);
    issue0(0, 1, 1, 0, 2'b11, 0, 32'h20,   32'h0,        32'h12347788, 0);
    issue0(0, 1, 1, 0, 2'b10, 0, 32'h11,   32'h0,        32'h0,        1);
    issue0(0, 1, 1, 0, 2'b01, 1, 32'h13,   32'h0,        32'h0,        1);
    issue0(0, 0, 0, 1, 2'b10, 0, 32'h12,   32'h00000000, 32'h0,        1);
    issue0(0, 0, 0, 1, 2'b01, 0, 32'h11,   32'h00000000, 32'h0,        1);
    issue0(0, 1, 1, 0, 2'b10, 0, 32'h10,   32'h0,        32'h80ADBEEF, 0);
    issue0(0, 1, 1, 0, 2'b10, 0, 32'h1010, 32'h0,        32'h80ADBEEF, 0);
    issue0(1, 0, 0, 1, 2'b10, 0, 32'h10,   32'h0BADF00D, 32'h0,        0);
    issue0(0, 1, 1, 0, 2'b10, 0, 32'h10,   32'h0,        32'h80ADBEEF, 0);
    issue0(0, 1, 0, 0, 2'b10, 0, 32'hCAFE0001, 32'h0,    32'h0,        0);
    in0.valid = 1'b0;
    @(posedge clk); #1;
    check("lat0_idle_valid_out", {31'd0, vo0}, 32'd0);
    check("lat0_idle_RegWriteOut", {31'd0, rwo0}, 32'd0);
    check("lat0_idle_ALUResult_hold", alu0, 32'hCAFE0001);
    check("lat0_idle_WriteReg_hold", {27'd0, wro0}, 32'd7);

    // LAT=3: rw, mr, mw, size, signed, addr, wdata, expected MemOut, misalign, flush cycle
    issue3(0, 0, 1, 2'b10, 0, 32'h40, 32'h11223344, 32'h0,        0, -1);
    issue3(1, 1, 0, 2'b10, 0, 32'h40, 32'h0,        32'h11223344, 0, -1);
    issue3(0, 0, 1, 2'b10, 0, 32'h40, 32'h99999999, 32'h0,        0, 2);
    issue3(1, 1, 0, 2'b00, 1, 32'h43, 32'h0,        32'h00000011, 0, -1);
    in3 = mk_in(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h00ABCDEF, 32'h0, 5'd9);
    q3.push_back(mk_exp(in3, 32'h0, 1'b0));
    @(negedge clk);
    check("lat3_alu_op_busy", {31'd0, busy3}, 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of a waiting store must abort it.
    in3 = mk_in(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hAAAA5555, 5'd9);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("rst_wait_valid_out3", {31'd0, vo3}, 32'd0);
    check("rst_wait_ALUResultOut3", alu3, 32'd0);
    check("rst_wait_WriteRegOut3", {27'd0, wro3}, 32'd0);
    check("rst_wait_busy3", {31'd0, busy3}, 32'd0);
    in3.valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy3", {31'd0, busy3}, 32'd0);
    @(posedge clk); #1;
    issue3(1, 1, 0, 2'b10, 0, 32'h40, 32'h0, 32'h11223344, 0, -1);
    in3.valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("lat0_queue_drained", q0.size(), 32'd0);
    check("lat3_queue_drained", q3.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
